fifo_ptr_ctrl: RTL and testbench

//  Write/read pointer generator for the FIFO. Sits directly upstream of

---
 rtl/fifo_ptr_ctrl_if.sv | 25 ++
 rtl/fifo_ptr_ctrl.sv | 81 ++++++++
 tb/tb_fifo_ptr_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fifo_ptr_ctrl_if.sv
// rtl/fifo_ptr_ctrl_if.sv - push/pop request and pointer/status bundle for fifo_ptr_ctrl
interface fifo_ptr_ctrl_if #(
    parameter int DEPTH_BIT = 4
);
    logic                 i_wr_req;
    logic                 i_rd_req;
    logic                 i_flush;
    logic                 o_wr_en;
    logic                 o_rd_en;
    logic [DEPTH_BIT-1:0] o_addrw;
    logic [DEPTH_BIT-1:0] o_addrr;
    logic [DEPTH_BIT-1:0] o_count;
    logic                 o_ovf;
    logic                 o_udf;

    modport master (
        output i_wr_req, i_rd_req, i_flush,
        input  o_wr_en, o_rd_en, o_addrw, o_addrr, o_count, o_ovf, o_udf
    );

    modport slave (
        input  i_wr_req, i_rd_req, i_flush,
        output o_wr_en, o_rd_en, o_addrw, o_addrr, o_count, o_ovf, o_udf
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO write/read pointer generator with occupancy FSM and sticky ovf/udf
module fifo_ptr_ctrl #(
    parameter int DEPTH_BIT = 4,
    parameter int DEPTH_MAX = 15
) (
    input  logic           i_clk,
    input  logic           i_rest,
    fifo_ptr_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL, S_FLUSH} state_t;

    localparam logic [DEPTH_BIT-1:0] CNT_MAX = DEPTH_BIT'(DEPTH_MAX);

    state_t               state, state_nxt;
    logic [DEPTH_BIT-1:0] addrw, addrw_nxt;
    logic [DEPTH_BIT-1:0] addrr, addrr_nxt;
    logic [DEPTH_BIT-1:0] count, count_nxt;
    logic                 ovf, ovf_nxt;
    logic                 udf, udf_nxt;
    logic                 wr_en, rd_en;

    always_ff @(posedge i_clk or negedge i_rest) begin
        if (!i_rest) begin
            state <= S_EMPTY;
            addrw <= '0;
            addrr <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            state <= state_nxt;
            addrw <= addrw_nxt;
            addrr <= addrr_nxt;
            count <= count_nxt;
            ovf   <= ovf_nxt;
            udf   <= udf_nxt;
        end
    end

    // Gating uses only local state; downstream full/empty flags lag by a cycle.
    always_comb begin
        wr_en     = i_rest & bus.i_wr_req & (state != S_FULL)  & (state != S_FLUSH) & ~bus.i_flush;
        rd_en     = i_rest & bus.i_rd_req & (state != S_EMPTY) & (state != S_FLUSH) & ~bus.i_flush;
        state_nxt = state;
        addrw_nxt = addrw;
        addrr_nxt = addrr;
        count_nxt = count;
        ovf_nxt   = ovf;
        udf_nxt   = udf;
        if (bus.i_flush) begin
            state_nxt = S_FLUSH;
            addrw_nxt = '0;
            addrr_nxt = '0;
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            udf_nxt   = 1'b0;
        end else if (state == S_FLUSH) begin
            state_nxt = S_EMPTY;
        end else begin
            addrw_nxt = addrw + DEPTH_BIT'(wr_en);
            addrr_nxt = addrr + DEPTH_BIT'(rd_en);
            count_nxt = count + DEPTH_BIT'(wr_en) - DEPTH_BIT'(rd_en);
            ovf_nxt   = ovf | (bus.i_wr_req & (state == S_FULL));
            udf_nxt   = udf | (bus.i_rd_req & (state == S_EMPTY));
            if (count_nxt == '0)
                state_nxt = S_EMPTY;
            else if (count_nxt == CNT_MAX)
                state_nxt = S_FULL;
            else
                state_nxt = S_PART;
        end
    end

    assign bus.o_wr_en = wr_en;
    assign bus.o_rd_en = rd_en;
    assign bus.o_addrw = addrw;
    assign bus.o_addrr = addrr;
    assign bus.o_count = count;
    assign bus.o_ovf   = ovf;
    assign bus.o_udf   = udf;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - directed self-checking bench for fifo_ptr_ctrl
module tb_fifo_ptr_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fifo_ptr_ctrl_if #(.DEPTH_BIT(4)) bus ();

    fifo_ptr_ctrl #(.DEPTH_BIT(4), .DEPTH_MAX(15)) dut (
        .i_clk  (clk),
        .i_rest (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic f);
        bus.i_wr_req = w;
        bus.i_rd_req = r;
        bus.i_flush  = f;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        #10;
        check("rst_addrw", 32'(bus.o_addrw), 0);
        check("rst_addrr", 32'(bus.o_addrr), 0);
        check("rst_count", 32'(bus.o_count), 0);
        check("rst_ovf",   32'(bus.o_ovf),   0);
        check("rst_udf",   32'(bus.o_udf),   0);
        drive(1'b1, 1'b0, 1'b0);
        check("rst_wr_en_gated", 32'(bus.o_wr_en), 0);
        drive(1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick();

        // push 3 from reset
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check("t1_wr_en",  32'(bus.o_wr_en), 1);
            check("t1_addrw",  32'(bus.o_addrw), 32'(i));
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        check("t1_wr_en_idle", 32'(bus.o_wr_en), 0);
        check("t1_addrw_end",  32'(bus.o_addrw), 3);
        check("t1_count_end",  32'(bus.o_count), 3);

        // flush back to empty, then fill to FULL
        drive(1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("t2_count0", 32'(bus.o_count), 0);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        check("t2_count_full", 32'(bus.o_count), 15);
        check("t2_addrw_full", 32'(bus.o_addrw), 15);
        check("t2_ovf_before", 32'(bus.o_ovf),   0);
        drive(1'b1, 1'b0, 1'b0);
        check("t2_wr_en_full", 32'(bus.o_wr_en), 0);
        tick();
        check("t2_ovf",        32'(bus.o_ovf),   1);
        check("t2_addrw_hold", 32'(bus.o_addrw), 15);
        check("t2_count_hold", 32'(bus.o_count), 15);

        // FULL with simultaneous push and pop
        drive(1'b1, 1'b1, 1'b0);
        check("t3_rd_en", 32'(bus.o_rd_en), 1);
        check("t3_wr_en", 32'(bus.o_wr_en), 0);
        tick();
        check("t3_count", 32'(bus.o_count), 14);
        check("t3_addrr", 32'(bus.o_addrr), 1);
        check("t3_addrw", 32'(bus.o_addrw), 15);
        check("t3_ovf",   32'(bus.o_ovf),   1);

        // bring both pointers to 14, keep one entry, then 20 push/pop pairs across the wrap
        drive(1'b0, 1'b0, 1'b1);
        tick();
        check("t4_flush_ovf", 32'(bus.o_ovf), 0);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
        end
        check("t4_addrw14", 32'(bus.o_addrw), 14);
        check("t4_addrr14", 32'(bus.o_addrr), 14);
        check("t4_count0",  32'(bus.o_count), 0);
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            check("t4_pair_en", 32'({bus.o_wr_en, bus.o_rd_en}), 3);
            tick();
            check("t4_count", 32'(bus.o_count), 1);
            check("t4_addrr", 32'(bus.o_addrr), (14 + i + 1) % 16);
            check("t4_addrw", 32'(bus.o_addrw), (15 + i + 1) % 16);
        end
        check("t4_addrr_end", 32'(bus.o_addrr), 2);
        check("t4_udf_none",  32'(bus.o_udf),   0);

        // drain, pop on empty, then flush with a push that must be dropped
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check("t5_count0", 32'(bus.o_count), 0);
        drive(1'b0, 1'b1, 1'b0);
        check("t5_rd_en_empty", 32'(bus.o_rd_en), 0);
        tick();
        check("t5_udf",   32'(bus.o_udf),   1);
        check("t5_addrr", 32'(bus.o_addrr), 3);
        drive(1'b1, 1'b0, 1'b1);
        check("t5_wr_en_flushreq", 32'(bus.o_wr_en), 0);
        tick();
        check("t5_flush_addrw", 32'(bus.o_addrw), 0);
        check("t5_flush_addrr", 32'(bus.o_addrr), 0);
        check("t5_flush_count", 32'(bus.o_count), 0);
        check("t5_flush_udf",   32'(bus.o_udf),   0);
        drive(1'b1, 1'b0, 1'b0);
        check("t5_wr_en_in_flush", 32'(bus.o_wr_en), 0);
        tick();
        check("t5_addrw_after_flush", 32'(bus.o_addrw), 0);
        drive(1'b1, 1'b0, 1'b0);
        check("t5_wr_en_empty", 32'(bus.o_wr_en), 1);
        tick();
        check("t5_addrw1", 32'(bus.o_addrw), 1);

        // burst to 7 entries, then async reset off the clock edge
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tick();
        end
        check("t6_count7", 32'(bus.o_count), 7);
        drive(1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_addrw", 32'(bus.o_addrw), 0);
        check("t6_rst_count", 32'(bus.o_count), 0);
        check("t6_rst_wr_en", 32'(bus.o_wr_en), 0);
        tick();
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        check("t6_wr_en_post", 32'(bus.o_wr_en), 1);
        check("t6_addrw_post", 32'(bus.o_addrw), 0);
        tick();
        check("t6_addrw1", 32'(bus.o_addrw), 1);
        check("t6_count1", 32'(bus.o_count), 1);
        drive(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
